// File: rtl/prec_conv_sched.sv
// prec_conv_sched: converts a NUM_ELEM float vector by time-sharing LANES precision_tran converters.
// Optional perf counters (perf_vec_cnt, perf_stall_cnt) are enabled by defining PREC_CONV_SCHED_PERF_EN.

module precision_tran #(
   parameter int EXP_WIDTH_IN   = 4,
   parameter int FRAC_WIDTH_IN  = 3,
   parameter int EXP_WIDTH_OUT  = 5,
   parameter int FRAC_WIDTH_OUT = 3
) (
   input  logic [EXP_WIDTH_IN+FRAC_WIDTH_IN:0]   a,
   output logic [EXP_WIDTH_OUT+FRAC_WIDTH_OUT:0] y,
   output logic                                  invalid,
   output logic                                  overflow,
   output logic                                  underflow
);
   localparam int EI       = EXP_WIDTH_IN;
   localparam int FI       = FRAC_WIDTH_IN;
   localparam int EO       = EXP_WIDTH_OUT;
   localparam int FO       = FRAC_WIDTH_OUT;
   localparam int BIAS_IN  = (1 << (EI - 1)) - 1;
   localparam int BIAS_OUT = (1 << (EO - 1)) - 1;
   localparam int EMAX_OUT = (1 << EO) - 2;
   localparam int XW       = ((EI > EO) ? EI : EO) + 2;
   localparam logic signed [XW-1:0] REBIAS_X = XW'(BIAS_OUT - BIAS_IN);
   localparam logic signed [XW-1:0] EMAX_X   = XW'(EMAX_OUT);
   localparam logic signed [XW-1:0] ONE_X    = XW'(1);

   logic                 sign;
   logic [EI-1:0]        exp_in;
   logic [FI-1:0]        frac_in;
   logic [FO-1:0]        frac_cv;
   logic [FO-1:0]        qnan_frac;
   logic signed [XW-1:0] exp_reb;

   assign sign    = a[EI+FI];
   assign exp_in  = a[EI+FI-1:FI];
   assign frac_in = a[FI-1:0];
   assign exp_reb = $signed({{(XW-EI){1'b0}}, exp_in}) + REBIAS_X;

   if (FO > FI) begin : g_frac_ext
      assign frac_cv = {frac_in, {(FO-FI){1'b0}}};
   end else if (FO == FI) begin : g_frac_same
      assign frac_cv = frac_in;
   end else begin : g_frac_trunc
      assign frac_cv = frac_in[FI-1 -: FO];
   end

   // Specials first, then the rebiased exponent is range-checked against the output format
   always_comb begin
      qnan_frac         = '0;
      qnan_frac[FO-1]   = 1'b1;
      y                 = '0;
      invalid           = 1'b0;
      overflow          = 1'b0;
      underflow         = 1'b0;
      if (exp_in == '1) begin
         if (frac_in != '0) begin
            y       = {1'b0, {EO{1'b1}}, qnan_frac};
            invalid = 1'b1;
         end else begin
            y = {sign, {EO{1'b1}}, {FO{1'b0}}};
         end
      end else if (exp_in == '0) begin
         y = {sign, {(EO+FO){1'b0}}};
      end else if (exp_reb > EMAX_X) begin
         y        = {sign, EO'(EMAX_OUT), {FO{1'b1}}};
         overflow = 1'b1;
      end else if (exp_reb < ONE_X) begin
         y         = {sign, {(EO+FO){1'b0}}};
         underflow = 1'b1;
      end else begin
         y = {sign, exp_reb[EO-1:0], frac_cv};
      end
   end
endmodule

module prec_conv_sched #(
   parameter int EXP_WIDTH_IN   = 4,
   parameter int FRAC_WIDTH_IN  = 3,
   parameter int EXP_WIDTH_OUT  = 5,
   parameter int FRAC_WIDTH_OUT = 3,
   parameter int NUM_ELEM       = 8,
   parameter int LANES          = 2,
   localparam int EW_IN  = EXP_WIDTH_IN + FRAC_WIDTH_IN + 1,
   localparam int EW_OUT = EXP_WIDTH_OUT + FRAC_WIDTH_OUT + 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_ELEM*EW_IN-1:0]  in_vec,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_ELEM*EW_OUT-1:0] out_vec,
   output logic                       out_invalid,
   output logic                       out_overflow,
   output logic                       out_underflow,
   output logic                       busy
`ifdef PREC_CONV_SCHED_PERF_EN
   ,
   output logic [31:0]                perf_vec_cnt,
   output logic [31:0]                perf_stall_cnt
`endif
);
   localparam int BEATS = NUM_ELEM / LANES;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   if (NUM_ELEM % LANES != 0) begin : g_bad_lanes
      $error("prec_conv_sched: NUM_ELEM must be a multiple of LANES");
   end

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t                     state;
   logic [CW-1:0]              beat;
   logic [NUM_ELEM*EW_IN-1:0]  src_vec;
   logic [EW_OUT-1:0]          lane_y [LANES];
   logic [LANES-1:0]           lane_inv;
   logic [LANES-1:0]           lane_ovf;
   logic [LANES-1:0]           lane_unf;

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      precision_tran #(
         .EXP_WIDTH_IN  (EXP_WIDTH_IN),
         .FRAC_WIDTH_IN (FRAC_WIDTH_IN),
         .EXP_WIDTH_OUT (EXP_WIDTH_OUT),
         .FRAC_WIDTH_OUT(FRAC_WIDTH_OUT)
      ) u_conv (
         .a        (src_vec[(int'(beat) * LANES + j) * EW_IN +: EW_IN]),
         .y        (lane_y[j]),
         .invalid  (lane_inv[j]),
         .overflow (lane_ovf[j]),
         .underflow(lane_unf[j])
      );
   end

   // Source is latched on accept so the producer may change in_vec during conversion
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         beat          <= '0;
         src_vec       <= '0;
         in_ready      <= 1'b1;
         out_valid     <= 1'b0;
         out_vec       <= '0;
         out_invalid   <= 1'b0;
         out_overflow  <= 1'b0;
         out_underflow <= 1'b0;
         busy          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  src_vec       <= in_vec;
                  beat          <= '0;
                  out_invalid   <= 1'b0;
                  out_overflow  <= 1'b0;
                  out_underflow <= 1'b0;
                  in_ready      <= 1'b0;
                  busy          <= 1'b1;
                  state         <= CONV;
               end
            end
            CONV: begin
               for (int j = 0; j < LANES; j++) begin
                  out_vec[(int'(beat) * LANES + j) * EW_OUT +: EW_OUT] <= lane_y[j];
               end
               out_invalid   <= out_invalid | (|lane_inv);
               out_overflow  <= out_overflow | (|lane_ovf);
               out_underflow <= out_underflow | (|lane_unf);
               if (beat == CW'(BEATS - 1)) begin
                  beat      <= '0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  beat <= beat + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PREC_CONV_SCHED_PERF_EN
   // Counters wrap naturally at 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_vec_cnt   <= '0;
         perf_stall_cnt <= '0;
      end else if (state == DONE) begin
         if (out_ready) perf_vec_cnt <= perf_vec_cnt + 32'd1;
         else           perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: doc/prec_conv_sched.md
Name: prec_conv_sched

Overview:
- Sequencing controller that converts a packed vector of NUM_ELEM floating-point elements from the input format to the output format.
- Shares LANES instances of the combinational precision_tran converter across the whole vector, so each vector takes NUM_ELEM/LANES conversion beats.
- Sits between the operand buffer and the tensor-core MAC array.
- Uses valid/ready handshakes on both sides and returns per-vector sticky exception flags.

Parameters:
- EXP_WIDTH_IN, 4, input exponent width
- FRAC_WIDTH_IN, 3, input fraction width
- EXP_WIDTH_OUT, 5, output exponent width
- FRAC_WIDTH_OUT, 3, output fraction width
- NUM_ELEM, 8, elements per vector
- LANES, 2, converter instances; NUM_ELEM must be a multiple of LANES (elaboration error otherwise)
- Derived: EW_IN=EXP_WIDTH_IN+FRAC_WIDTH_IN+1, EW_OUT=EXP_WIDTH_OUT+FRAC_WIDTH_OUT+1, BEATS=NUM_ELEM/LANES, CW=max(1,clog2(BEATS))

Ports:
- clk, input, 1, clock
- rst, input, 1, synchronous active-high reset
- in_valid, input, 1, input vector valid
- in_ready, output, 1, block can accept a vector
- in_vec, input, NUM_ELEM*EW_IN, element i at bits [i*EW_IN +: EW_IN]
- out_valid, output, 1, converted vector valid
- out_ready, input, 1, consumer accepts
- out_vec, output, NUM_ELEM*EW_OUT, element i at bits [i*EW_OUT +: EW_OUT]
- out_invalid, output, 1, OR of converter invalid over the vector
- out_overflow, output, 1, OR of converter overflow over the vector
- out_underflow, output, 1, OR of converter underflow over the vector
- busy, output, 1, high in CONV or DONE

Behaviour:
- Single clock domain clk; rst is synchronous and active-high.
- Reset state: IDLE; beat counter=0; in_ready=1; out_valid=0; out_vec=0; all three flags=0; busy=0.
- FSM states are IDLE, CONV and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready: latch in_vec into the source register, clear the sticky flags, set beat=0, go to CONV.
- CONV:
  - in_ready=0.
  - Each cycle, lane j converts element beat*LANES+j.
  - The lane results are written to out_vec slots beat*LANES+j.
  - Each lane's invalid/overflow/underflow is ORed into the sticky flags.
  - beat increments by 1. At beat==BEATS-1 the write completes and the FSM goes to DONE; beat wraps to 0.
- DONE:
  - out_valid=1.
  - out_vec and the flags hold stable while out_valid&!out_ready.
  - On out_ready: out_valid falls, go to IDLE.
- Latency: accept at edge N → out_valid at edge N+BEATS (with defaults, 4 cycles after the accept edge).
- Throughput: one vector per BEATS+2 cycles; no overlap. in_ready is low in CONV and DONE.
- out_vec slots not yet written in CONV keep their previous-vector values. They are not observable until out_valid.
- Per-element conversion semantics are exactly those of precision_tran:
  - NaN → canonical quiet NaN with invalid asserted.
  - Inf → inf.
  - Zero and subnormal → signed zero.
  - Exponent rebias with saturation; fraction truncated or zero-extended.
- Flags are sticky per vector and cleared only on accept of the next vector or on reset.
- in_vec changing after the accept has no effect, because the source is latched.
- Reset asserted mid-CONV or mid-DONE:
  - Returns to IDLE next edge with reset values.
  - The partial vector is discarded and out_valid is never raised for it.
- in_valid while not in IDLE is ignored (no accept). The producer must hold it.
- BEATS==1: CONV lasts exactly one cycle.

Optional Feature:
- Macro: PREC_CONV_SCHED_PERF_EN.
- When defined:
  - Adds output perf_vec_cnt [31:0], which increments on each completed out handshake.
  - Adds output perf_stall_cnt [31:0], which increments each cycle in DONE with out_ready=0.
  - Both counters reset to 0 on rst and wrap modulo 2^32.
- When undefined: neither port nor counter exists and the behaviour is otherwise identical.

Test Plan:
- Basic conversion:
  - Stimulus: defaults, in_vec all elements 0x38 (+1.0 E4M3), out_ready=1.
  - Required: out_valid exactly 4 cycles after the accept edge; every out element 0x078; flags 0; in_ready back to 1 the cycle after the out handshake.
- Special values:
  - Stimulus: element0=0x79 (NaN), element3=0x78 (+inf), element5=0x80 (-0), element6=0x01 (subnormal), others 0x38.
  - Required: out elements 0x0FC, 0x0F8, 0x100, 0x000 at those positions; out_invalid=1; overflow=0; underflow=0.
- Flag clearing:
  - Stimulus: a vector containing a NaN followed by an all-0x38 vector.
  - Required: the second vector reports out_invalid=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE, while in_valid=1 with a new vector.
  - Required: out_vec and flags stable; in_ready=0 throughout; new vector accepted only after the handshake; with PREC_CONV_SCHED_PERF_EN defined, perf_stall_cnt=5.
- Reset mid-operation:
  - Stimulus: assert rst at beat 2 of CONV.
  - Required: next cycle state IDLE, in_ready=1, out_valid=0, flags 0; no out_valid for the aborted vector.
- Parameter sweep:
  - Stimulus: LANES=8 (BEATS=1) and LANES=1 (BEATS=8) with a random vector.
  - Required: out_valid 1 and 8 cycles after accept respectively; per-element results match the precision_tran model.
